arb_gnt_responder: RTL

// - Grant-side responder for the row-level fixed-priority arbiter in the pixel hierarchy.
// - Latches per-row pixel events and drives them as requests into the arbiter.
// - Consumes the arbiter's one-hot grant, encodes it to a binary row address and ships an address-event word downstream with valid/ready.
// - Pulses a one-hot acknowledge that clears the served row's pending request.

---
 rtl/arb_gnt_responder_pkg.sv | 23 ++
 rtl/arb_gnt_responder_if.sv | 39 +++
 rtl/arb_gnt_responder_onehot_to_bin.sv | 21 ++
 rtl/arb_gnt_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/arb_gnt_responder_pkg.sv
// Shared types for the row-level arbiter grant responder.
// ARB_TIMESTAMP_EN adds a timestamp field to the outgoing address-event word.
package arb_gnt_responder_pkg;

    localparam int ARB_LVL_ROWS = 4;
    localparam int AER_ADDR_W   = $clog2(ARB_LVL_ROWS);
    localparam int TS_W         = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_ACK
    } arb_rsp_state_t;

    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic                  pol;
`ifdef ARB_TIMESTAMP_EN
        logic [TS_W-1:0]       ts;
`endif
    } aer_word_t;

endpackage

// File: rtl/arb_gnt_responder_if.sv
// Row request/grant/ack lines plus the downstream AER valid/ready bus.
// ARB_TIMESTAMP_EN adds the aer_ts field.
interface arb_gnt_responder_if
    import arb_gnt_responder_pkg::*;
#(
    parameter int LVL_ROWS = ARB_LVL_ROWS,
    parameter int ADDR_W   = $clog2(LVL_ROWS)
);
    logic [LVL_ROWS-1:0] evt;
    logic [LVL_ROWS-1:0] pol;
    logic [LVL_ROWS-1:0] req;
    logic [LVL_ROWS-1:0] gnt;
    logic [LVL_ROWS-1:0] ack;
    logic                aer_valid;
    logic                aer_ready;
    logic [ADDR_W-1:0]   aer_addr;
    logic                aer_pol;
`ifdef ARB_TIMESTAMP_EN
    logic [TS_W-1:0]     aer_ts;
`endif

    // master: the responder, which sources the AER word
    modport master (
        input  evt, pol, gnt, aer_ready,
        output req, ack, aer_valid, aer_addr, aer_pol
`ifdef ARB_TIMESTAMP_EN
        , output aer_ts
`endif
    );

    modport slave (
        output evt, pol, gnt, aer_ready,
        input  req, ack, aer_valid, aer_addr, aer_pol
`ifdef ARB_TIMESTAMP_EN
        , input aer_ts
`endif
    );

endinterface

// File: rtl/arb_gnt_responder_onehot_to_bin.sv
// One-hot to binary index encoder; lowest set bit wins, flags multi-hot input.
module onehot_to_bin #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] oh_i,
    output logic [W-1:0] idx_o,
    output logic         not_onehot_o
);

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (oh_i[i]) idx_o = W'(i);
        end
    end

    assign not_onehot_o = |(oh_i & (oh_i - N'(1)));

endmodule

// File: rtl/arb_gnt_responder.sv
// Grant-side responder: latches row events as arbiter requests, ships granted rows
// as AER words over valid/ready and acks the served row. ARB_TIMESTAMP_EN adds aer_ts.
module arb_gnt_responder
    import arb_gnt_responder_pkg::*;
#(
    parameter int LVL_ROWS = ARB_LVL_ROWS,
    parameter int ADDR_W   = $clog2(LVL_ROWS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    arb_gnt_responder_if.master bus,
    output logic                gnt_err_o
);

    // The word struct is fixed-width in the package, so the row count must match it.
    if (LVL_ROWS < 2) begin : g_rows_chk
        $error("arb_gnt_responder: LVL_ROWS must be >= 2");
    end
    if (ADDR_W != AER_ADDR_W) begin : g_addr_chk
        $error("arb_gnt_responder: ADDR_W must equal AER_ADDR_W of the package");
    end

    arb_rsp_state_t      state_q, state_d;
    logic [LVL_ROWS-1:0] pend_q, pend_d;
    logic [LVL_ROWS-1:0] pol_q, pol_d;
    logic [LVL_ROWS-1:0] gnt_q, gnt_d;
    logic [LVL_ROWS-1:0] clr;
    aer_word_t           word_q, word_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   gnt_idx;
    logic                gnt_multi;
    logic                gnt_stray;
`ifdef ARB_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q;
`endif

    onehot_to_bin #(
        .N (LVL_ROWS),
        .W (ADDR_W)
    ) u_enc (
        .oh_i         (bus.gnt),
        .idx_o        (gnt_idx),
        .not_onehot_o (gnt_multi)
    );

    assign gnt_stray = |(bus.gnt & ~pend_q);

    // A fresh event outranks the ack clear, so a re-fired row is never lost.
    for (genvar r = 0; r < LVL_ROWS; r++) begin : g_row
        assign pend_d[r] = bus.evt[r] | (pend_q[r] & ~clr[r]);
        assign pol_d[r]  = bus.evt[r] ? bus.pol[r] : pol_q[r];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        word_d  = word_q;
        err_d   = err_q;
        clr     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|bus.gnt) begin
                    if (gnt_multi || gnt_stray) err_d = 1'b1;
                    if (!gnt_stray) begin
                        gnt_d       = LVL_ROWS'(1) << gnt_idx;
                        word_d.addr = gnt_idx;
                        word_d.pol  = pol_q[gnt_idx];
`ifdef ARB_TIMESTAMP_EN
                        word_d.ts   = ts_q;
`endif
                        state_d     = ARB_SEND;
                    end
                end
            end
            ARB_SEND: begin
                if (bus.aer_ready) state_d = ARB_ACK;
            end
            ARB_ACK: begin
                clr     = gnt_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            pend_q  <= '0;
            pol_q   <= '0;
            gnt_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
`ifdef ARB_TIMESTAMP_EN
            ts_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pol_q   <= pol_d;
            gnt_q   <= gnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
`ifdef ARB_TIMESTAMP_EN
            ts_q    <= ts_q + TS_W'(1);
`endif
        end
    end

    assign bus.req       = pend_q;
    assign bus.ack       = (state_q == ARB_ACK) ? gnt_q : '0;
    assign bus.aer_valid = (state_q == ARB_SEND);
    assign bus.aer_addr  = word_q.addr;
    assign bus.aer_pol   = word_q.pol;
`ifdef ARB_TIMESTAMP_EN
    assign bus.aer_ts    = word_q.ts;
`endif
    assign gnt_err_o     = err_q;

endmodule
